// File: rtl/dcache_pkg.sv
// Shared geometry, FSM state encoding and byte helpers for the direct-mapped write-back data cache.
package dcache_pkg;

    localparam int TAG_W      = 3;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int NUM_LINES  = 8;
    localparam int BLOCK_W    = 32;
    localparam int MEM_ADDR_W = TAG_W + INDEX_W;
    localparam int STAT_W     = 16;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        UPDATE
    } state_t;

    function automatic logic [7:0] select_byte(input logic [BLOCK_W-1:0] blk,
                                               input logic [OFFSET_W-1:0] off);
        return blk[{off, 3'b000} +: 8];
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] val);
        return (val == {STAT_W{1'b1}}) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/dcache_fsm.sv
// Miss-handling controller: sequences write-back and refill against main memory
// and owns every memory-side output.
module dcache_fsm
    import dcache_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req,
    input  logic                  i_miss,
    input  logic                  i_victim_dirty,
    input  logic [TAG_W-1:0]      i_victim_tag,
    input  logic [TAG_W-1:0]      i_req_tag,
    input  logic [INDEX_W-1:0]    i_index,
    input  logic [BLOCK_W-1:0]    i_victim_block,
    input  logic                  i_mem_busywait,
    output logic                  o_idle,
    output logic                  o_update,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic [MEM_ADDR_W-1:0] o_mem_address,
    output logic [BLOCK_W-1:0]    o_mem_writedata
);

    state_t r_state;

    assign o_idle   = (r_state == IDLE);
    assign o_update = (r_state == UPDATE);

    // Memory strobes are registered, so a transfer state has always driven its
    // strobe for a full cycle before the first edge that can end it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= IDLE;
            o_mem_read      <= 1'b0;
            o_mem_write     <= 1'b0;
            o_mem_address   <= '0;
            o_mem_writedata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_miss) begin
                        if (i_victim_dirty) begin
                            r_state         <= WRITEBACK;
                            o_mem_write     <= 1'b1;
                            o_mem_address   <= {i_victim_tag, i_index};
                            o_mem_writedata <= i_victim_block;
                        end else begin
                            r_state       <= FETCH;
                            o_mem_read    <= 1'b1;
                            o_mem_address <= {i_req_tag, i_index};
                        end
                    end
                end
                WRITEBACK: begin
                    if (!i_mem_busywait) begin
                        o_mem_write <= 1'b0;
                        if (i_req) begin
                            r_state       <= FETCH;
                            o_mem_read    <= 1'b1;
                            o_mem_address <= {i_req_tag, i_index};
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                FETCH: begin
                    // A withdrawn request drops the refill rather than installing
                    // a block under a tag the CPU is no longer presenting.
                    if (!i_mem_busywait) begin
                        o_mem_read <= 1'b0;
                        r_state    <= i_req ? UPDATE : IDLE;
                    end
                end
                UPDATE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    o_mem_read  <= 1'b0;
                    o_mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/data_cache.sv
// 8-line direct-mapped write-back data cache with 4-byte blocks.
// Define DCACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module data_cache
    import dcache_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] HIT_COUNT,
    output logic [15:0] MISS_COUNT
`endif
);

    logic [BLOCK_W-1:0]   r_data [NUM_LINES];
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;

    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_index;
    logic [OFFSET_W-1:0] w_offset;
    logic                w_req;
    logic                w_hit;
    logic                w_miss;
    logic                w_idle;
    logic                w_update;
    logic                w_write_hit;

    assign w_tag    = ADDRESS[7:5];
    assign w_index  = ADDRESS[4:2];
    assign w_offset = ADDRESS[1:0];
    assign w_req    = READ | WRITE;
    assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_miss   = w_req && !w_hit;

    // A simultaneous READ and WRITE is a store; the load path still shows the old byte.
    assign w_write_hit = WRITE && w_hit && w_idle;

    // Gating with RESET keeps the stall low while the arrays are held invalid.
    assign BUSYWAIT = RESET && w_miss;
    assign READDATA = (READ && w_hit) ? select_byte(r_data[w_index], w_offset) : 8'h00;

    dcache_fsm u_fsm (
        .i_clk           (CLK),
        .i_rst_n         (RESET),
        .i_req           (w_req),
        .i_miss          (w_miss),
        .i_victim_dirty  (r_valid[w_index] && r_dirty[w_index]),
        .i_victim_tag    (r_tag[w_index]),
        .i_req_tag       (w_tag),
        .i_index         (w_index),
        .i_victim_block  (r_data[w_index]),
        .i_mem_busywait  (MEM_BUSYWAIT),
        .o_idle          (w_idle),
        .o_update        (w_update),
        .o_mem_read      (MEM_READ),
        .o_mem_write     (MEM_WRITE),
        .o_mem_address   (MEM_ADDRESS),
        .o_mem_writedata (MEM_WRITEDATA)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_update) begin
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
        end else if (w_write_hit) begin
            r_dirty[w_index] <= 1'b1;
        end
    end

    // Payload arrays carry no reset; valid bits alone decide whether they matter.
    always_ff @(posedge CLK) begin
        if (w_update) begin
            r_data[w_index] <= MEM_READDATA;
            r_tag[w_index]  <= w_tag;
        end else if (w_write_hit) begin
            r_data[w_index][{w_offset, 3'b000} +: 8] <= WRITEDATA;
        end
    end

`ifdef DCACHE_STATS_EN
    logic              r_missed;
    logic [STAT_W-1:0] r_hit_count;
    logic [STAT_W-1:0] r_miss_count;

    // r_missed stops the hit that finally serves a missed request from counting as a hit.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_missed     <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (w_idle) begin
            if (w_miss) begin
                r_miss_count <= sat_inc(r_miss_count);
                r_missed     <= 1'b1;
            end else if (w_req) begin
                if (!r_missed) begin
                    r_hit_count <= sat_inc(r_hit_count);
                end
                r_missed <= 1'b0;
            end else begin
                r_missed <= 1'b0;
            end
        end
    end

    assign HIT_COUNT  = r_hit_count;
    assign MISS_COUNT = r_miss_count;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache with a fixed-latency block memory model.
module tb_data_cache;

    localparam int MEM_LAT = 3;
    localparam int WAIT_LIMIT = 200;

    logic        clk = 1'b0;
    logic        rstN;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writeData;
    logic [7:0]  readData;
    logic        busyWait;
    logic        memRead;
    logic        memWrite;
    logic [5:0]  memAddress;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;
    logic        memBusy;
`ifdef DCACHE_STATS_EN
    logic [15:0] hitCount;
    logic [15:0] missCount;
`endif

    int checks = 0;
    int fails  = 0;

    data_cache dut (
        .CLK           (clk),
        .RESET         (rstN),
        .READ          (read),
        .WRITE         (write),
        .ADDRESS       (address),
        .WRITEDATA     (writeData),
        .READDATA      (readData),
        .BUSYWAIT      (busyWait),
        .MEM_READ      (memRead),
        .MEM_WRITE     (memWrite),
        .MEM_ADDRESS   (memAddress),
        .MEM_WRITEDATA (memWriteData),
        .MEM_READDATA  (memReadData),
        .MEM_BUSYWAIT  (memBusy)
`ifdef DCACHE_STATS_EN
        ,
        .HIT_COUNT     (hitCount),
        .MISS_COUNT    (missCount)
`endif
    );

    always #5 clk = ~clk;

    // Memory: busy for MEM_LAT cycles of an asserted strobe, then completes.
    logic [31:0] mem [64];
    bit   [63:0] memHas;
    int          memCnt;

    function automatic logic [31:0] memDefault(input logic [5:0] a);
        case (a)
            6'h01:   return 32'hDDCCBBAA;
            6'h09:   return 32'h44332211;
            6'h03:   return 32'hA3A2A1A0;
            default: return {4{2'b00, a}};
        endcase
    endfunction

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            memCnt <= 0;
        end else if (memRead || memWrite) begin
            if (memCnt < MEM_LAT) begin
                memCnt <= memCnt + 1;
            end else begin
                memCnt <= 0;
                if (memWrite) begin
                    mem[memAddress]    <= memWriteData;
                    memHas[memAddress] <= 1'b1;
                end
            end
        end else begin
            memCnt <= 0;
        end
    end

    assign memBusy     = (memRead || memWrite) && (memCnt < MEM_LAT);
    assign memReadData = memHas[memAddress] ? mem[memAddress] : memDefault(memAddress);

    int          readCycles  = 0;
    int          writeCycles = 0;
    int          overlaps    = 0;
    logic [5:0]  lastFetchAddr = '0;
    logic [5:0]  lastWbAddr = '0;
    logic [31:0] lastWbData = '0;

    always @(negedge clk) begin
        if (memRead && memWrite) overlaps++;
        if (memRead) begin
            readCycles++;
            lastFetchAddr = memAddress;
        end
        if (memWrite) begin
            writeCycles++;
            lastWbAddr = memAddress;
            lastWbData = memWriteData;
        end
    end

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       expBusy;
        logic [7:0] expRdata;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] addr,
                                 input logic [7:0] wd);
        @(posedge clk);
        #1;
        read      = rd;
        write     = wr;
        address   = addr;
        writeData = wd;
    endtask

    task automatic waitServed(output int stalls);
        bit ok;
        ok = 1'b0;
        stalls = 0;
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            @(negedge clk);
            if (!busyWait) begin
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        if (!ok) begin
            checks++;
            fails++;
            $display("[TB] FAIL serve_timeout: BUSYWAIT still 1 after %0d cycles, expected 0", WAIT_LIMIT);
        end
    endtask

    task automatic waitMemRead(input logic level, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            @(negedge clk);
            if (memRead == level) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rstN  = 1'b0;
        read  = 1'b0;
        write = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    initial begin
        int stalls;
        int rdBefore;
        int wrBefore;

        vecs[0] = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 8'hBB};
        vecs[1] = '{1'b1, 1'b0, 8'h06, 8'h00, 1'b0, 8'hCC};
        vecs[2] = '{1'b1, 1'b0, 8'h04, 8'h00, 1'b0, 8'hAA};
        vecs[3] = '{1'b1, 1'b0, 8'h07, 8'h00, 1'b0, 8'hDD};
        vecs[4] = '{1'b0, 1'b0, 8'h05, 8'h00, 1'b0, 8'h00};
        vecs[5] = '{1'b0, 1'b1, 8'h04, 8'h77, 1'b0, 8'h00};
        vecs[6] = '{1'b1, 1'b0, 8'h04, 8'h00, 1'b0, 8'h77};
        vecs[7] = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 8'hBB};

        rstN      = 1'b0;
        read      = 1'b0;
        write     = 1'b0;
        address   = 8'h00;
        writeData = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("reset_busywait", {31'd0, busyWait}, 32'd0);
        checkOutput("reset_mem_read", {31'd0, memRead}, 32'd0);
        checkOutput("reset_mem_write", {31'd0, memWrite}, 32'd0);
        checkOutput("reset_mem_address", {26'd0, memAddress}, 32'd0);
        checkOutput("reset_mem_writedata", memWriteData, 32'd0);
        checkOutput("reset_readdata", {24'd0, readData}, 32'd0);
        read    = 1'b1;
        address = 8'h05;
        #1;
        checkOutput("reset_busywait_with_read", {31'd0, busyWait}, 32'd0);
        read = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;

        // Cold miss on line 1, clean victim.
        applyStimulus(1'b1, 1'b0, 8'h05, 8'h00);
        #1;
        checkOutput("cold_miss_busywait", {31'd0, busyWait}, 32'd1);
        checkOutput("cold_miss_readdata", {24'd0, readData}, 32'd0);
        waitServed(stalls);
        checkOutput("cold_miss_penalty", stalls, MEM_LAT + 1 + 2);
        checkOutput("cold_miss_fetch_addr", {26'd0, lastFetchAddr}, 32'h01);
        checkOutput("cold_miss_readdata_bb", {24'd0, readData}, 32'hBB);

        rdBefore = readCycles;
        applyStimulus(1'b1, 1'b0, 8'h06, 8'h00);
        waitServed(stalls);
        checkOutput("hit_zero_stall", stalls, 0);
        checkOutput("hit_readdata_cc", {24'd0, readData}, 32'hCC);
        checkOutput("hit_no_mem_read", readCycles - rdBefore, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_busywait", i), {31'd0, busyWait}, {31'd0, vecs[i].expBusy});
            checkOutput($sformatf("vec%0d_readdata", i), {24'd0, readData}, {24'd0, vecs[i].expRdata});
        end

        // Conflict miss on the dirty line 1: write-back then refill.
        rdBefore = readCycles;
        wrBefore = writeCycles;
        applyStimulus(1'b1, 1'b0, 8'h24, 8'h00);
        waitServed(stalls);
        checkOutput("wb_penalty", stalls, 2 * (MEM_LAT + 1) + 2);
        checkOutput("wb_address", {26'd0, lastWbAddr}, 32'h01);
        checkOutput("wb_data", lastWbData, 32'hDDCCBB77);
        checkOutput("wb_write_cycles", writeCycles - wrBefore, MEM_LAT + 1);
        checkOutput("wb_fetch_addr", {26'd0, lastFetchAddr}, 32'h09);
        checkOutput("wb_fetch_cycles", readCycles - rdBefore, MEM_LAT + 1);
        checkOutput("wb_readdata", {24'd0, readData}, 32'h11);

        // READ and WRITE together on a hit store the byte.
        applyStimulus(1'b1, 1'b1, 8'h25, 8'h99);
        @(negedge clk);
        checkOutput("rw_busywait", {31'd0, busyWait}, 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h25, 8'h00);
        @(negedge clk);
        checkOutput("rw_write_took", {24'd0, readData}, 32'h99);

        // Reset in the middle of a refill.
        applyStimulus(1'b1, 1'b0, 8'h0C, 8'h00);
        waitMemRead(1'b1, "abort_fetch_started");
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("abort_mem_read", {31'd0, memRead}, 32'd0);
        checkOutput("abort_mem_write", {31'd0, memWrite}, 32'd0);
        checkOutput("abort_busywait", {31'd0, busyWait}, 32'd0);
        checkOutput("abort_mem_address", {26'd0, memAddress}, 32'd0);
        read = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;

        wrBefore = writeCycles;
        applyStimulus(1'b1, 1'b0, 8'h05, 8'h00);
        #1;
        checkOutput("post_reset_miss", {31'd0, busyWait}, 32'd1);
        waitServed(stalls);
        checkOutput("post_reset_penalty", stalls, MEM_LAT + 1 + 2);
        checkOutput("post_reset_no_wb", writeCycles - wrBefore, 0);
        checkOutput("post_reset_readdata", {24'd0, readData}, 32'hBB);

        // Request withdrawn one cycle into a refill.
        applyStimulus(1'b1, 1'b0, 8'h0C, 8'h00);
        waitMemRead(1'b1, "withdraw_fetch_started");
        applyStimulus(1'b0, 1'b0, 8'h0C, 8'h00);
        waitMemRead(1'b0, "withdraw_fetch_finished");
        repeat (2) @(negedge clk);
        checkOutput("withdraw_idle_mem_read", {31'd0, memRead}, 32'd0);
        checkOutput("withdraw_idle_mem_write", {31'd0, memWrite}, 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h0C, 8'h00);
        waitServed(stalls);
        checkOutput("withdraw_reissue_readdata", {24'd0, readData}, 32'hA0);

`ifdef DCACHE_STATS_EN
        doReset();
        checkOutput("stats_reset_hits", {16'd0, hitCount}, 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h05, 8'h00);
        waitServed(stalls);
        applyStimulus(1'b1, 1'b0, 8'h06, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h07, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h04, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h04, 8'h00);
        @(negedge clk);
        checkOutput("stats_miss_count", {16'd0, missCount}, 32'd1);
        checkOutput("stats_hit_count", {16'd0, hitCount}, 32'd3);
`else
        doReset();
`endif

        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        checkOutput("mem_rw_exclusive", overlaps, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
